// File: rtl/axi_reg_cmd_sequencer_pkg.sv
// Shared definitions for the register-command sequencer: register width,
// downstream command codes, request opcodes and the sequencer state type.
package axi_reg_cmd_sequencer_pkg;

   localparam int REG_WIDTH = 32;

   // Downstream command codes (existing register-command front end encoding)
   localparam logic [REG_WIDTH-1:0] CMD_NOP   = 32'h0000_0000;
   localparam logic [REG_WIDTH-1:0] CMD_WRITE = 32'h0000_0001;
   localparam logic [REG_WIDTH-1:0] CMD_READ  = 32'h0000_0002;

   // Request opcodes carried on req_op
   localparam logic SEQ_OP_WRITE = 1'b0;
   localparam logic SEQ_OP_READ  = 1'b1;

   // Read-latency down-counter width; RD_LATENCY is limited to 1..15
   localparam int LAT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SET_ADDR,
      SET_DATA,
      ISSUE_WR,
      GAP,
      ISSUE_RD,
      WAIT_RD,
      RESP
   } seq_state_t;

   // Read-back mismatch restricted to the bits the caller cares about
   function automatic logic verify_mismatch(input logic [REG_WIDTH-1:0] read_back,
                                            input logic [REG_WIDTH-1:0] written,
                                            input logic [REG_WIDTH-1:0] mask);
      return |((read_back ^ written) & mask);
   endfunction

endpackage

// File: rtl/axi_reg_cmd_sequencer_if.sv
// Request/response stream between a requester (software bridge or loader FSM)
// and the register-command sequencer.
interface axi_reg_cmd_sequencer_if;
   import axi_reg_cmd_sequencer_pkg::*;

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_op;
   logic [REG_WIDTH-1:0] req_addr;
   logic [REG_WIDTH-1:0] req_data;

   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [REG_WIDTH-1:0] rsp_data;
   logic                 rsp_err;

   // Requester side
   modport master (
      output req_valid, req_op, req_addr, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_op, req_addr, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/axi_reg_cmd_sequencer.sv
// Register-command sequencer: turns one write/read request into the fixed
// address -> data -> command pulse -> NOP phasing on the downstream register
// interface and returns exactly one response per request.
// Build option: define SEQ_WRITE_VERIFY_EN to follow every write with a
// read-back of the same address and flag mismatches on rsp_err.
module axi_reg_cmd_sequencer
   import axi_reg_cmd_sequencer_pkg::*;
#(
   parameter int unsigned          RD_LATENCY  = 2,
   parameter logic [REG_WIDTH-1:0] VERIFY_MASK = 32'h0000_FFFF
) (
   input  logic                      clk,
   input  logic                      rst,
   axi_reg_cmd_sequencer_if.slave    seq,
   output logic [REG_WIDTH-1:0]      address_register,
   output logic [REG_WIDTH-1:0]      data_in_register,
   output logic [REG_WIDTH-1:0]      cmd_register,
   input  logic [REG_WIDTH-1:0]      data_o_register,
   output logic                      busy,
   output logic [15:0]               txn_count
);

   // state    | meaning
   // ---------+-------------------------------------------------------------
   // IDLE     | req_ready high, waiting for a request
   // SET_ADDR | address_register shows the request address
   // SET_DATA | data_in_register shows the write data
   // ISSUE_WR | CMD_WRITE on cmd_register (one cycle)
   // GAP      | CMD_NOP after the write pulse
   // ISSUE_RD | CMD_READ on cmd_register (one cycle), latency count starts
   // WAIT_RD  | CMD_NOP, counting down to the read-data sample edge
   // RESP     | rsp_valid high, outputs held until rsp_ready

   // Counter value in the ISSUE_RD cycle; data is sampled on the edge where it is 0
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY - 1);

   seq_state_t           state;
   logic                 op_q;
   logic [REG_WIDTH-1:0] data_q;
   logic [LAT_W-1:0]     lat_cnt;
   logic                 req_ready_q;
   logic                 rsp_valid_q;
   logic [REG_WIDTH-1:0] rsp_data_q;
   logic                 rsp_err_q;
   logic                 read_err;

`ifdef SEQ_WRITE_VERIFY_EN
   // Only a read issued on behalf of a write is a verify read
   assign read_err = (op_q == SEQ_OP_WRITE) &&
                     verify_mismatch(data_o_register, data_q, VERIFY_MASK);
`else
   logic unused_verify_mask;
   assign unused_verify_mask = ^VERIFY_MASK;
   assign read_err           = 1'b0;
`endif

   assign seq.req_ready = req_ready_q;
   assign seq.rsp_valid = rsp_valid_q;
   assign seq.rsp_data  = rsp_data_q;
   assign seq.rsp_err   = rsp_err_q;

   // Sequencer FSM; every output is registered and set on entry to the state
   // in which it must be visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         op_q             <= SEQ_OP_WRITE;
         data_q           <= '0;
         lat_cnt          <= '0;
         req_ready_q      <= 1'b1;
         rsp_valid_q      <= 1'b0;
         rsp_data_q       <= '0;
         rsp_err_q        <= 1'b0;
         address_register <= '0;
         data_in_register <= '0;
         cmd_register     <= CMD_NOP;
         busy             <= 1'b0;
         txn_count        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (seq.req_valid) begin
                  op_q             <= seq.req_op;
                  data_q           <= seq.req_data;
                  address_register <= seq.req_addr;
                  req_ready_q      <= 1'b0;
                  busy             <= 1'b1;
                  state            <= SET_ADDR;
               end
            end

            SET_ADDR: begin
               if (op_q == SEQ_OP_WRITE) begin
                  data_in_register <= data_q;
                  state            <= SET_DATA;
               end else begin
                  cmd_register <= CMD_READ;
                  lat_cnt      <= LAT_INIT;
                  state        <= ISSUE_RD;
               end
            end

            SET_DATA: begin
               cmd_register <= CMD_WRITE;
               state        <= ISSUE_WR;
            end

            ISSUE_WR: begin
               cmd_register <= CMD_NOP;
               state        <= GAP;
            end

            GAP: begin
`ifdef SEQ_WRITE_VERIFY_EN
               cmd_register <= CMD_READ;
               lat_cnt      <= LAT_INIT;
               state        <= ISSUE_RD;
`else
               rsp_data_q  <= '0;
               rsp_err_q   <= 1'b0;
               rsp_valid_q <= 1'b1;
               state       <= RESP;
`endif
            end

            // ISSUE_RD shares the countdown so RD_LATENCY=1 samples on its own edge
            ISSUE_RD, WAIT_RD: begin
               cmd_register <= CMD_NOP;
               if (lat_cnt == '0) begin
                  rsp_data_q  <= data_o_register;
                  rsp_err_q   <= read_err;
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
                  state   <= WAIT_RD;
               end
            end

            RESP: begin
               if (seq.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy        <= 1'b0;
                  txn_count   <= txn_count + 16'd1;
                  state       <= IDLE;
               end
            end

            default: begin
               cmd_register <= CMD_NOP;
               rsp_valid_q  <= 1'b0;
               req_ready_q  <= 1'b1;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_reg_cmd_sequencer.sv
// Self-checking bench for axi_reg_cmd_sequencer: randomized requests, a
// 16-bit-wide downstream register model with exact read latency, and a
// scoreboard of expected responses derived from request-level rules.
// Define SEQ_WRITE_VERIFY_EN for both bench and RTL to exercise verify writes.
module tb_axi_reg_cmd_sequencer;
   import axi_reg_cmd_sequencer_pkg::*;

   localparam int          RD_LAT   = 2;
   localparam logic [31:0] MASK     = 32'h0000_FFFF;
   localparam logic [31:0] DEV_MASK = 32'h0000_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] address_register, data_in_register, cmd_register;
   logic [31:0] data_o_register = '0;
   logic        busy;
   logic [15:0] txn_count;

   axi_reg_cmd_sequencer_if bus ();

   axi_reg_cmd_sequencer #(.RD_LATENCY(RD_LAT), .VERIFY_MASK(MASK)) dut (
      .clk              (clk),
      .rst              (rst),
      .seq              (bus),
      .address_register (address_register),
      .data_in_register (data_in_register),
      .cmd_register     (cmd_register),
      .data_o_register  (data_o_register),
      .busy             (busy),
      .txn_count        (txn_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_data;
      logic        exp_err;
      int          t_req;
      int          lat;
   } exp_t;

   exp_t        q[$];
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] dmem    [logic [31:0]];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          hs_count = 0;
   bit          in_flight = 0;
   bit          rsp_seen = 0;
   bit          hold_rsp = 0;
   bit          corrupt = 0;
   bit          preload = 0;
   logic [15:0] exp_cnt = '0;
   int          cur_nwr = 0;
   int          cur_nrd = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Downstream register block: 16-bit storage, read data valid only in the
   // cycle RD_LAT-1 after the CMD_READ cycle, garbage otherwise.
   initial begin
      int age;
      age = 99;
      forever begin
         @(negedge clk);
         if (cmd_register == CMD_WRITE) dmem[address_register] = data_in_register & DEV_MASK;
         if (cmd_register == CMD_READ) age = 0;
         else if (age < 99) age++;
         if (age == RD_LAT - 1)
            data_o_register = (dmem.exists(address_register) ? dmem[address_register] : 32'h0)
                              ^ (corrupt ? 32'h1 : 32'h0);
         else
            data_o_register = $urandom;
      end
   end

   // Response consumer with random backpressure
   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor / scoreboard
   initial begin
      exp_t        e;
      logic [31:0] rb;
      forever begin
         @(negedge clk);
         if (rst) begin
            q.delete();
            in_flight = 0;
            rsp_seen  = 0;
            exp_cnt   = '0;
         end else begin
            if (preload) exp_cnt = 16'hFFFF;
            check("busy", 32'(busy), 32'(in_flight));
            check("req_ready", 32'(bus.req_ready), 32'(!in_flight));
            check("txn_count", 32'(txn_count), 32'(exp_cnt));

            if (cmd_register != CMD_NOP) begin
               if (q.size() == 0) check("cmd_when_idle", cmd_register, CMD_NOP);
               else begin
                  e = q[0];
                  if (cmd_register == CMD_WRITE) begin
                     cur_nwr++;
                     check("wr_cycle", cyc - e.t_req, 3);
                     check("wr_addr", address_register, e.addr);
                     check("wr_data", data_in_register, e.data);
                  end else if (cmd_register == CMD_READ) begin
                     cur_nrd++;
                     check("rd_cycle", cyc - e.t_req, (e.op == SEQ_OP_READ) ? 2 : 5);
                     check("rd_addr", address_register, e.addr);
                  end else check("cmd_code", cmd_register, CMD_NOP);
               end
            end

            if (bus.rsp_valid) begin
               if (q.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 0);
               else begin
                  e = q[0];
                  if (!rsp_seen) begin
                     check("rsp_latency", cyc - e.t_req, e.lat);
                     check("rsp_data", bus.rsp_data, e.exp_data);
                     check("rsp_err", 32'(bus.rsp_err), 32'(e.exp_err));
                     check("n_cmd_wr", cur_nwr, (e.op == SEQ_OP_WRITE) ? 1 : 0);
`ifdef SEQ_WRITE_VERIFY_EN
                     check("n_cmd_rd", cur_nrd, 1);
`else
                     check("n_cmd_rd", cur_nrd, (e.op == SEQ_OP_READ) ? 1 : 0);
`endif
                     rsp_seen = 1;
                  end else begin
                     check("hold_data", bus.rsp_data, e.exp_data);
                     check("hold_err", 32'(bus.rsp_err), 32'(e.exp_err));
                  end
                  if (bus.rsp_ready) begin
                     void'(q.pop_front());
                     exp_cnt++;
                     in_flight = 0;
                     rsp_seen  = 0;
                  end
               end
            end else if (rsp_seen) begin
               check("rsp_dropped", 32'(bus.rsp_valid), 1);
               rsp_seen = 0;
            end

            if (in_flight && q.size() != 0 && !rsp_seen && (cyc - q[0].t_req) > 100) begin
               check("rsp_timeout", 0, 1);
               void'(q.pop_front());
               in_flight = 0;
            end

            if (bus.req_valid && bus.req_ready) begin
               e.op    = bus.req_op;
               e.addr  = bus.req_addr;
               e.data  = bus.req_data;
               e.t_req = cyc;
               if (bus.req_op == SEQ_OP_READ) begin
                  e.exp_data = ref_rd(bus.req_addr);
                  e.exp_err  = 1'b0;
                  e.lat      = 2 + RD_LAT;
               end else begin
                  ref_mem[bus.req_addr] = bus.req_data & DEV_MASK;
`ifdef SEQ_WRITE_VERIFY_EN
                  rb         = (bus.req_data & DEV_MASK) ^ (corrupt ? 32'h1 : 32'h0);
                  e.exp_data = rb;
                  e.exp_err  = ((rb ^ bus.req_data) & MASK) != 0;
                  e.lat      = 5 + RD_LAT;
`else
                  e.exp_data = 32'h0;
                  e.exp_err  = 1'b0;
                  e.lat      = 5;
`endif
               end
               q.push_back(e);
               in_flight = 1;
               cur_nwr   = 0;
               cur_nrd   = 0;
               hs_count++;
            end
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 of the cycle after the handshake
   task automatic send(input logic op, input logic [31:0] a, input logic [31:0] d);
      int start;
      int n;
      start = hs_count;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = a;
      bus.req_data  = d;
      while (hs_count == start && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (hs_count == start) check("req_timeout", 0, 1);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_data  = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((in_flight || q.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 300) check("idle_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.req_valid = 1'b0;
      bus.req_op    = 1'b0;
      bus.req_addr  = '0;
      bus.req_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_addr", address_register, 0);
      check("rst_data_in", data_in_register, 0);
      check("rst_cmd", cmd_register, CMD_NOP);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_txn_count", 32'(txn_count), 0);

      // Reset asserted during the CMD_WRITE cycle drops the request
      @(posedge clk); #1;
      send(SEQ_OP_WRITE, 32'h0000_0F00, 32'h1234_5678);
      @(posedge clk);
      @(posedge clk);
      #2;
      check("pre_rst_cmd", cmd_register, CMD_WRITE);
      rst = 1'b1;
      #1;
      check("async_rst_cmd", cmd_register, CMD_NOP);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_rsp", 32'(bus.rsp_valid), 0);
      check("async_rst_txn", 32'(txn_count), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed write then read of address 0
      send(SEQ_OP_WRITE, 32'h0, 32'hDEAD_BEEF);
      wait_idle();
      send(SEQ_OP_READ, 32'h0, 32'h0);
      wait_idle();

      // Response held off for 5 cycles
      hold_rsp = 1;
      send(SEQ_OP_READ, 32'h0, 32'h0);
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("hold_rsp_seen", 32'(bus.rsp_valid), 1);
      repeat (5) @(posedge clk);
      #1;
      hold_rsp = 0;
      wait_idle();

`ifdef SEQ_WRITE_VERIFY_EN
      send(SEQ_OP_WRITE, 32'h10, 32'hDEAD_BEEF);
      wait_idle();
      corrupt = 1;
      send(SEQ_OP_WRITE, 32'h10, 32'hDEAD_BEEF);
      wait_idle();
      corrupt = 0;
`endif

      // Randomized traffic
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom);
      end
      wait_idle();

      // txn_count wrap
      @(posedge clk); #1;
      force dut.txn_count = 16'hFFFF;
      preload = 1;
      @(posedge clk); #1;
      release dut.txn_count;
      preload = 0;
      @(posedge clk); #1;
      send(SEQ_OP_READ, 32'h4, 32'h0);
      wait_idle();
      @(posedge clk); #1;
      check("txn_wrap", 32'(txn_count), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
